// File: rtl/mult_div_unit_if.sv
// Request/response bundle for mult_div_unit: operands and start in, HI/LO results and status out.
interface mult_div_unit_if;
   logic        start;
   logic        MultOrDiv;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        Div0;

   modport master (output start, MultOrDiv, a, b, input hi, lo, busy, done, Div0);
   modport slave  (input start, MultOrDiv, a, b, output hi, lo, busy, done, Div0);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit
// with MIPS-style HI/LO result registers; 32 iterations per operation.
module mult_div_unit (
   input  logic            clk,
   input  logic            reset,
   mult_div_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_e;

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [32:0] acc_q, acc_d;      // Booth partial product high half / division remainder
   logic [31:0] qr_q, qr_d;        // multiplier shifting out / quotient shifting in
   logic        qm1_q, qm1_d;      // Booth q[-1] bit
   logic [31:0] m_q, m_d;          // multiplicand or divisor magnitude
   logic        op_q, op_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic        dz_q, dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        div0_q, div0_d;

   logic [32:0] sum;
   logic [32:0] shifted;
   logic [32:0] trial;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      qr_d      = qr_q;
      qm1_d     = qm1_q;
      m_d       = m_q;
      op_d      = op_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      div0_d    = 1'b0;
      sum       = acc_q;
      shifted   = {acc_q[31:0], qr_q[31]};
      trial     = shifted - {1'b0, m_q};

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               op_d   = bus.MultOrDiv;
               cnt_d  = 6'd0;
               busy_d = 1'b1;
               acc_d  = 33'd0;
               qm1_d  = 1'b0;
               dz_d   = 1'b0;
               if (!bus.MultOrDiv) begin
                  m_d     = bus.a;
                  qr_d    = bus.b;
                  state_d = MULT;
               end else begin
                  m_d       = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
                  qr_d      = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
                  neg_quo_d = bus.a[31] ^ bus.b[31];
                  neg_rem_d = bus.a[31];
                  dz_d      = (bus.b == 32'd0);
                  state_d   = (bus.b == 32'd0) ? FINISH : DIV;
               end
            end
         end
         MULT: begin
            // Multiplicand sign-extended to 33 bits so subtracting -2^31 cannot overflow.
            case ({qr_q[0], qm1_q})
               2'b01:   sum = acc_q + {m_q[31], m_q};
               2'b10:   sum = acc_q - {m_q[31], m_q};
               default: sum = acc_q;
            endcase
            acc_d = {sum[32], sum[32:1]};
            qr_d  = {sum[0], qr_q[31:1]};
            qm1_d = qr_q[0];
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = FINISH;
         end
         DIV: begin
            // Borrow out of the 33-bit trial subtraction means the divisor did not fit.
            if (!trial[32]) begin
               acc_d = trial;
               qr_d  = {qr_q[30:0], 1'b1};
            end else begin
               acc_d = shifted;
               qr_d  = {qr_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = FINISH;
         end
         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (dz_q) begin
               div0_d = 1'b1;
            end else if (!op_q) begin
               hi_d = acc_q[31:0];
               lo_d = qr_q;
            end else begin
               lo_d = neg_quo_q ? (~qr_q + 32'd1) : qr_q;
               hi_d = neg_rem_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= 6'd0;
         acc_q     <= 33'd0;
         qr_q      <= 32'd0;
         qm1_q     <= 1'b0;
         m_q       <= 32'd0;
         op_q      <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         div0_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         qr_q      <= qr_d;
         qm1_q     <= qm1_d;
         m_q       <= m_d;
         op_q      <= op_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         div0_q    <= div0_d;
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.Div0 = div0_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
REQ-004 start  input  1  request pulse from the control unit, sampled on the clk rising edge.
REQ-005 MultOrDiv  input  1  operation select, sampled with start: 0=signed mult, 1=signed div.
REQ-006 a  input  32  operand A (multiplicand / dividend), two's complement.
REQ-007 b  input  32  operand B (multiplier / divisor), two's complement.
REQ-008 hi  output  32  HI result register.
REQ-009 lo  output  32  LO result register.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse: results are valid.
REQ-012 Div0  output  1  one-cycle pulse: divide by zero detected.

Function
REQ-013 The FSM SHALL have 4 states: IDLE, MULT, DIV, FINISH.
REQ-014 In IDLE, start=1 SHALL latch a, b and MultOrDiv, clear the iteration counter, and set busy=1.
REQ-015 If start=1 at edge k, the FSM SHALL enter MULT or DIV at edge k.
REQ-016 MULT SHALL perform radix-2 Booth signed multiplication, one iteration per cycle.
REQ-017 DIV SHALL perform restoring division on magnitudes, one quotient bit per cycle.
REQ-018 The iteration counter SHALL be 6 bits wide.
REQ-019 MULT and DIV SHALL each run exactly 32 iterations, on edges k+1..k+32.
REQ-020 After the 32nd iteration the FSM SHALL enter FINISH.
REQ-021 At edge k+33 (FINISH->IDLE), the FSM SHALL update hi/lo, set done=1 and set busy=0.
REQ-022 done SHALL clear at edge k+34.
REQ-023 Mult result: the full signed 64-bit product; hi = bits[63:32], lo = bits[31:0].
REQ-024 Div result: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-025 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no exception flag.
REQ-026 Div with b=0 at start: the FSM SHALL go IDLE->FINISH at edge k and perform no iterations.
REQ-027 For that case, at edge k+1 the block SHALL pulse done=1 and Div0=1 for one cycle; hi/lo SHALL be unchanged.
REQ-028 Div0 SHALL be 0 for all other operations.
REQ-029 start while busy=1 (states MULT, DIV or FINISH) SHALL be ignored; operands are not re-latched.
REQ-030 start at the same edge where done rises SHALL be ignored, because the FSM is not yet in IDLE.
REQ-031 start at the edge where done falls SHALL be accepted.
REQ-032 hi/lo SHALL hold their value between operations and change only at a FINISH exit.
REQ-033 Operand inputs SHALL be don't-care after the start edge.

Reset
REQ-034 Asynchronously on reset=0, the block SHALL set state=IDLE, hi=0, lo=0, busy=0, done=0, Div0=0 and counter=0.
REQ-035 Reset asserted mid-operation SHALL abort it immediately; no done pulse follows, and hi/lo=0.
REQ-036 After reset deasserts, the first start at a clk edge SHALL be accepted normally.

Verification
REQ-037 Scenario: mult a=7, b=0xFFFFFFFD -> at k+33: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done for exactly 1 cycle.
REQ-038 Scenario: mult a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-039 Scenario: div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, Div0=0.
REQ-040 Scenario: div a=5, b=0, with prior hi=0x1111, lo=0x2222 -> at k+1: done=1, Div0=1; hi/lo unchanged; busy low at k+1.
REQ-041 Scenario: start again at k+10 with different operands during a mult -> ignored; results match the first operands; exactly one done pulse.
REQ-042 Scenario: reset=0 at k+15 of a div -> busy=0, hi=lo=0 immediately; no done pulse; a new mult after release completes in 33 cycles.
